lsu_mem: RTL
============

# lsu_mem

Load/store unit for the MEM stage of the 5-stage RISC-V core. It sits between `exu` and the data-memory bus and consumes `exu` results: `alu_out` as the effective address and `rs2_data_o` as the store data, decoded by `opcode_o` and `funct3_o`. It performs byte-lane alignment, write strobes, load sign/zero extension and a req/gnt/rvalid handshake with data memory. It stalls the pipeline while an access is outstanding and drives the EX/MEM forwarding pair (`rd_ex_mem`, `rd_data_ex_mem`) back into `exu`.

## Interface
Parameters: none (32-bit datapath fixed).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  EX result valid this cycle
- ex_opcode  in  7  from `opcode_o`
- ex_funct3  in  3  from `funct3_o`
- ex_rd  in  5  destination register
- ex_alu_out  in  32  address or ALU result
- ex_rs2_data  in  32  store data (already forwarded)
- ex_ready  out  1  high when IDLE (accepts new op)
- stall  out  1  `~ex_ready`; freezes IF/ID/EX
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- wb_valid  out  1  write-back valid (one-cycle pulse)
- wb_rd  out  5  write-back register
- wb_data  out  32  write-back value
- rd_ex_mem  out  5  forwarding register index (= wb_rd when wb_valid, else 0)
- rd_data_ex_mem  out  32  forwarding data (= wb_data)
- misalign_err  out  1  one-cycle pulse for misaligned or illegal access

## Operation
- Load opcode 7'b0000011, store 7'b0100011. Every other opcode is pass-through: `wb_data = ex_alu_out`.
- Accept an op when `ex_valid & ex_ready`. All `ex_*` inputs are latched at accept.
- FSM states: IDLE, REQ, RESP.
  - IDLE: on accept of a legal load or store, go to REQ. Pass-through ops stay in IDLE.
  - REQ: `mem_req = 1` until `mem_gnt`. Store with gnt goes to IDLE (complete). Load with gnt goes to RESP.
  - RESP: wait for `mem_rvalid`, then go to IDLE (complete). `mem_rvalid` is ignored in IDLE and REQ.
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other funct3 is illegal.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] ≠ 0. Misaligned and illegal ops issue no bus access and no wb. `misalign_err` pulses the cycle after accept, and the FSM stays in IDLE.
- Store lanes, with `o = addr[1:0]`:
  - sb: `wstrb = 4'b0001 << o`, `wdata = {4{rs2[7:0]}}`.
  - sh: `wstrb = 4'b0011 << o`, `wdata = {2{rs2[15:0]}}`.
  - sw: `wstrb = 4'b1111`, `wdata = rs2`.
- Load extract: `sh = mem_rdata >> (8*o)`. lb/lh sign-extend from bit 7/15. lbu/lhu zero-extend. lw uses the word as-is.
- Stores produce no wb. Loads to x0 still access the bus and still pulse `wb_valid` with `wb_rd = 0`.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are held stable while `mem_req` is high. They are 0 when `mem_req` is low.

## Timing
- Reset values: every output is 0 except `ex_ready = 1` (and therefore `stall = 0`). The FSM goes to IDLE.
- Pass-through: accepted in cycle N, `wb_valid` in cycle N+1. No stall, throughput 1/cycle.
- Memory op accepted in cycle N:
  - `mem_req` rises in N+1 and `stall` goes high in N+1.
  - Store: gnt in cycle G, back to IDLE at G+1.
  - Load: gnt in cycle G, rvalid earliest in G+1 (cycle R). At R+1, `wb_valid`/`wb_data` are registered and the FSM is in IDLE with `ex_ready = 1`. Minimum load latency is 3 cycles from accept to wb.
- `wb_valid` and `misalign_err` are single-cycle registered pulses.
- Back-to-back: a new op is accepted in the same cycle that `ex_ready` returns high.
- Reset asserted mid-access: at the next edge, state is IDLE and `mem_req = 0`. No wb pulse is produced, and a late `mem_rvalid` is dropped.

## Test plan
- Pass-through add result 0x0000_1234 to rd=5 -> `wb_valid` next cycle, `wb_rd = 5`, `wb_data = 0x0000_1234`, `stall` never high.
- sb, addr 0x103, rs2 0xAABBCCDD, gnt after 2 cycles -> `mem_addr = 0x100`, `wstrb = 4'b1000`, `wdata = 0xDDDDDDDD`, `stall` for 3 cycles, no wb.
- lb at 0x201 with rdata 0x1234_80FF, gnt immediately, rvalid 1 cycle later -> `wb_data = 0xFFFF_FF80`. The same access as lbu -> `0x0000_0080`.
- lh at 0x202 with rdata 0x8001_0000 -> `wb_data = 0xFFFF_8001`. lw at 0x206 -> `misalign_err` pulse, `mem_req` never high, no wb.
- Load in RESP with `rst_n = 0` for one cycle, then rvalid -> state IDLE, no `wb_valid`, outputs at reset values.
- Load, then immediately an add -> the add is accepted the cycle `ex_ready` rises. `wb_valid` pulses twice in order, and `rd_ex_mem`/`rd_data_ex_mem` track each pulse.

Source files
------------

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit: byte-lane alignment, write strobes, load extension
// and a req/gnt/rvalid data-memory handshake, with EX/MEM forwarding outputs.
module lsu_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2_data,
  output logic        ex_ready,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_ex_mem,
  output logic [31:0] rd_data_ex_mem,
  output logic        misalign_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;
  logic [4:0]  op_rd;

  logic        accept_c;
  logic        is_load_c;
  logic        is_store_c;
  logic        legal_c;
  logic        misaligned_c;
  logic [1:0]  off_c;
  logic [3:0]  st_wstrb_c;
  logic [31:0] st_wdata_c;
  logic [31:0] ld_shift_c;
  logic [31:0] ld_data_c;

  // Decode, legality and store lane placement for the op presented by EX.
  always_comb begin
    accept_c     = ex_valid & ex_ready;
    is_load_c    = (ex_opcode == OP_LOAD);
    is_store_c   = (ex_opcode == OP_STORE);
    off_c        = ex_alu_out[1:0];
    legal_c      = 1'b0;
    misaligned_c = 1'b0;
    st_wstrb_c   = 4'b0000;
    st_wdata_c   = 32'h0;
    if (is_load_c) begin
      legal_c = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    end else if (is_store_c) begin
      legal_c = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    end
    case (ex_funct3[1:0])
      2'b01:   misaligned_c = off_c[0];
      2'b10:   misaligned_c = (off_c != 2'b00);
      default: misaligned_c = 1'b0;
    endcase
    case (ex_funct3[1:0])
      2'b00: begin
        st_wstrb_c = 4'b0001 << off_c;
        st_wdata_c = {4{ex_rs2_data[7:0]}};
      end
      2'b01: begin
        st_wstrb_c = 4'b0011 << off_c;
        st_wdata_c = {2{ex_rs2_data[15:0]}};
      end
      default: begin
        st_wstrb_c = 4'b1111;
        st_wdata_c = ex_rs2_data;
      end
    endcase
  end

  // Load extract from the returned word using the offset latched at accept.
  always_comb begin
    ld_shift_c = mem_rdata >> {op_off, 3'b000};
    case (op_funct3)
      3'b000:  ld_data_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      3'b001:  ld_data_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      3'b100:  ld_data_c = {24'h0, ld_shift_c[7:0]};
      3'b101:  ld_data_c = {16'h0, ld_shift_c[15:0]};
      default: ld_data_c = mem_rdata;
    endcase
  end

  // FSM with registered outputs; wb/forwarding/error are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      op_funct3      <= 3'b000;
      op_off         <= 2'b00;
      op_rd          <= 5'd0;
      ex_ready       <= 1'b1;
      stall          <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 32'h0;
      mem_wdata      <= 32'h0;
      mem_wstrb      <= 4'b0000;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_data        <= 32'h0;
      rd_ex_mem      <= 5'd0;
      rd_data_ex_mem <= 32'h0;
      misalign_err   <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_data        <= 32'h0;
      rd_ex_mem      <= 5'd0;
      rd_data_ex_mem <= 32'h0;
      misalign_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            if (!is_load_c && !is_store_c) begin
              wb_valid       <= 1'b1;
              wb_rd          <= ex_rd;
              wb_data        <= ex_alu_out;
              rd_ex_mem      <= ex_rd;
              rd_data_ex_mem <= ex_alu_out;
            end else if (!legal_c || misaligned_c) begin
              misalign_err <= 1'b1;
            end else begin
              state     <= S_REQ;
              ex_ready  <= 1'b0;
              stall     <= 1'b1;
              op_funct3 <= ex_funct3;
              op_off    <= off_c;
              op_rd     <= ex_rd;
              mem_req   <= 1'b1;
              mem_we    <= is_store_c;
              mem_addr  <= {ex_alu_out[31:2], 2'b00};
              mem_wdata <= is_store_c ? st_wdata_c : 32'h0;
              mem_wstrb <= is_store_c ? st_wstrb_c : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            if (mem_we) begin
              state    <= S_IDLE;
              ex_ready <= 1'b1;
              stall    <= 1'b0;
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            state          <= S_IDLE;
            ex_ready       <= 1'b1;
            stall          <= 1'b0;
            wb_valid       <= 1'b1;
            wb_rd          <= op_rd;
            wb_data        <= ld_data_c;
            rd_ex_mem      <= op_rd;
            rd_data_ex_mem <= ld_data_c;
          end
        end
        default: begin
          state    <= S_IDLE;
          ex_ready <= 1'b1;
          stall    <= 1'b0;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
